tdm_demux8: RTL
===============

Name: tdm_demux8

Overview:
- 1-to-8 time-division demultiplexer, the receive end of the 8:1 slot-multiplexed serial path.
- Takes a slot-serial stream, one sample per slot, with slot 0 marked by a sync flag.
- Rebuilds each 8-slot frame in a shadow buffer, then presents all 8 channels in parallel with a one-cycle frame strobe.
- Sits between the serial link and per-channel consumers.

Parameters:
- W, 1, bits per channel sample.
- NCH, 8, channels per frame. Fixed at 8; the slot index is 3 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  W  serial sample for the current slot.
- din_valid  in  1  din and sync are valid this cycle.
- sync  in  1  this sample is slot 0. Qualified by din_valid.
- dout  out  8*W  assembled frame. Channel k occupies bits [k*W +: W].
- dout_valid  out  1  one-cycle pulse when dout updates.
- slot  out  3  index the next accepted sample will be written to.
- locked  out  1  block is in RUN.
- sync_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async, rst=1):
  - state=HUNT, slot=0, shadow=0.
  - dout=0, dout_valid=0, locked=0, sync_err=0.
  - Reset mid-frame discards the partial frame; dout does not update.
- States: HUNT and RUN. locked = (state==RUN), registered.
- HUNT:
  - Samples without sync are ignored.
  - On din_valid && sync: shadow[0]=din, slot=1, go to RUN.
- RUN, on each din_valid:
  - Write shadow[slot]=din, then slot=slot+1 with wrap 7->0.
- Frame completion:
  - Triggered when the slot-7 sample is accepted.
  - Next edge: dout = {din, shadow[6..0]}, dout_valid=1 for exactly one cycle, slot=0.
  - Latency: dout_valid is asserted in the cycle after the slot-7 sample. dout holds its value until the next completion.
- Sync arriving mid-frame (din_valid && sync && slot!=0 in RUN):
  - Partial frame discarded; no dout update.
  - sync_err pulses for one cycle.
  - The sample is taken as slot 0: shadow[0]=din, slot=1, stay in RUN.
- Sync at slot 0 in RUN: normal; no error.
- No sync at slot 0 in RUN: see Optional Feature.
- din_valid=0: no state change; slot holds. Gaps between samples are allowed at any slot.
- Slot-7 sample arriving with sync: mid-frame rule applies. The frame is not emitted.
- Shadow contents from a discarded frame are don't-care. Every slot is rewritten before the next emit.
- dout_valid and sync_err are never asserted in HUNT, except the sync_err that occurs on a strict-mode drop (see below).

Optional Feature:
- Macro: TDM_SYNC_STRICT_EN.
- Defined:
  - Each frame must start with sync.
  - din_valid && !sync at slot 0 in RUN gives: sync_err pulse, state=HUNT, locked=0, sample dropped, slot=0.
  - dout keeps its last value.
- Undefined (default):
  - Missing sync at slot 0 is accepted (flywheel mode). The sample is written to slot 0 and no error is raised.
  - Only mid-frame sync raises sync_err.

Decomposition:
- Shared package tdm_pkg:
  - Constants NCH=8 and SLOT_W=3.
  - State typedef for HUNT/RUN.
  - Shared with the transmit-side mux and its slot counter.
- One natural sub-module: tdm_slot_ctr.
  - 3-bit slot counter with enable, load-to-1, clear and wrap flag.
  - Reusable on the transmit side.
- Shadow buffer and output register stay in the top module.

Test Plan:
- Reset then normal frame:
  - Stimulus: rst pulse; W=1; samples 1,0,1,1,0,0,1,0 in slots 0..7 with sync on slot 0, din_valid continuous.
  - Expected: dout=8'b01001101, dout_valid high one cycle after the slot-7 sample, locked=1.
- Back-to-back frames with gaps:
  - Stimulus: two frames, din_valid dropped for 3 cycles at slot 4 of the first frame.
  - Expected: exactly two dout_valid pulses; second frame data correct; slot held at 4 during the gap.
- Mid-frame resync:
  - Stimulus: sync at slot 5.
  - Expected: sync_err pulse; no dout_valid; slot=1 next cycle; the following 7 samples complete a frame with the resync sample as ch0.
- Async reset mid-frame:
  - Stimulus: assert rst between clock edges at slot 3.
  - Expected: dout=0, locked=0, slot=0 immediately. Non-sync samples after release are ignored until sync.
- Missing sync at slot 0:
  - Stimulus: a frame boundary with no sync on slot 0.
  - With TDM_SYNC_STRICT_EN: sync_err pulse, locked=0, old dout retained.
  - Without it: frame emitted normally, no sync_err.
- W=8 frame:
  - Stimulus: W=8; slots carry 0x00..0x07.
  - Expected: dout=64'h0706050403020100.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-slot TDM mux/demux pair: frame geometry and link state.
package tdm_pkg;

   localparam int NCH    = 8;
   localparam int SLOT_W = 3;

   typedef enum logic [0:0] {
      HUNT = 1'b0,
      RUN  = 1'b1
   } tdm_state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// 3-bit slot counter with enable, load-to-1, clear and a last-slot wrap flag.
// Clear has priority over load, load over enable.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load1,
   input  logic              clr,
   output logic [SLOT_W-1:0] slot,
   output logic              wrap
);

   logic [SLOT_W-1:0] slot_r;

   // slot index register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_r <= 3'd0;
      end else if (clr) begin
         slot_r <= 3'd0;
      end else if (load1) begin
         slot_r <= 3'd1;
      end else if (en) begin
         slot_r <= slot_r + 3'd1;
      end else begin
         slot_r <= slot_r;
      end
   end

   assign slot = slot_r;
   assign wrap = (slot_r == 3'd7);

endmodule

// File: rtl/tdm_demux8.sv
// 1-to-8 TDM demultiplexer: rebuilds sync-marked 8-slot frames and emits them in parallel.
// Optional TDM_SYNC_STRICT_EN: a frame without sync on slot 0 drops lock instead of flywheeling.
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter int W = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   din,
   input  logic           din_valid,
   input  logic           sync,
   output logic [8*W-1:0] dout,
   output logic           dout_valid,
   output logic [2:0]     slot,
   output logic           locked,
   output logic           sync_err
);

   tdm_state_e        state_r, state_nx_s;
   logic [W-1:0]      shadow_r [NCH];
   logic [8*W-1:0]    dout_r, frame_s;
   logic              dout_valid_r, sync_err_r, locked_r;
   logic [SLOT_W-1:0] slot_s, wr_idx_s;
   logic              wrap_s, wr_en_s, emit_s, err_s;
   logic              ctr_en_s, ctr_load_s, ctr_clr_s;

   tdm_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (ctr_en_s),
      .load1 (ctr_load_s),
      .clr   (ctr_clr_s),
      .slot  (slot_s),
      .wrap  (wrap_s)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= HUNT;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // next state, shadow write control and frame/error events
   always_comb begin
      state_nx_s = state_r;
      wr_en_s    = 1'b0;
      wr_idx_s   = slot_s;
      ctr_en_s   = 1'b0;
      ctr_load_s = 1'b0;
      ctr_clr_s  = 1'b0;
      emit_s     = 1'b0;
      err_s      = 1'b0;
      case (state_r)
         HUNT: begin
            if (din_valid && sync) begin
               wr_en_s    = 1'b1;
               wr_idx_s   = 3'd0;
               ctr_load_s = 1'b1;
               state_nx_s = RUN;
            end else begin
               state_nx_s = HUNT;
            end
         end
         RUN: begin
            if (!din_valid) begin
               state_nx_s = RUN;
            end else if (sync && (slot_s != 3'd0)) begin
               // resync: the sample restarts the frame as channel 0
               err_s      = 1'b1;
               wr_en_s    = 1'b1;
               wr_idx_s   = 3'd0;
               ctr_load_s = 1'b1;
            end else if (!sync && (slot_s == 3'd0)) begin
`ifdef TDM_SYNC_STRICT_EN
               err_s      = 1'b1;
               ctr_clr_s  = 1'b1;
               state_nx_s = HUNT;
`else
               wr_en_s    = 1'b1;
               ctr_en_s   = 1'b1;
`endif
            end else begin
               wr_en_s  = 1'b1;
               ctr_en_s = 1'b1;
               emit_s   = wrap_s;
            end
         end
         default: begin
            state_nx_s = HUNT;
            ctr_clr_s  = 1'b1;
         end
      endcase
   end

   // channel 7 comes straight from din on the completing cycle
   always_comb begin
      frame_s = '0;
      for (int k = 0; k < NCH - 1; k++) begin
         frame_s[k*W +: W] = shadow_r[k];
      end
      frame_s[(NCH-1)*W +: W] = din;
   end

   // shadow buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            shadow_r[k] <= '0;
         end
      end else if (wr_en_s) begin
         shadow_r[wr_idx_s] <= din;
      end else begin
         shadow_r <= shadow_r;
      end
   end

   // registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_r       <= '0;
         dout_valid_r <= 1'b0;
         sync_err_r   <= 1'b0;
         locked_r     <= 1'b0;
      end else begin
         dout_r       <= emit_s ? frame_s : dout_r;
         dout_valid_r <= emit_s;
         sync_err_r   <= err_s;
         locked_r     <= (state_nx_s == RUN);
      end
   end

   assign dout       = dout_r;
   assign dout_valid = dout_valid_r;
   assign sync_err   = sync_err_r;
   assign locked     = locked_r;
   assign slot       = slot_s;

endmodule
